main_control_fsm: RTL and testbench

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/mips_ctrl_pkg.sv | 44 ++++
 rtl/ctrl_out_decode.sv | 107 ++++++++++
 rtl/main_control_fsm.sv | 98 +++++++++
 tb/tb_main_control_fsm.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: FSM state encodings,
// primary opcodes and the ALU-control class codes carried on alu_op.
// Used by main_control_fsm, ctrl_out_decode and alu_control.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IEX    = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // alu_op classes: bit2 load/store add, bit1 branch subtract, bit0 funct-decoded
    localparam logic [2:0] ALU_OP_NONE  = 3'b000;
    localparam logic [2:0] ALU_OP_ADD   = 3'b100;
    localparam logic [2:0] ALU_OP_SUB   = 3'b010;
    localparam logic [2:0] ALU_OP_FUNCT = 3'b001;

    // I-type ALU instructions executed through IEX/IWB
    function automatic logic is_itype(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
               (op == OP_ORI)  || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Moore output decode for the control FSM: state (+ mem_ready in FETCH) -> datapath controls.
// Ports: state, mem_ready, rst in; all datapath control outputs except illegal out.
// While rst is high every output is forced to 0; JUMP outputs exist only with MIPS_JUMP_EN.
import mips_ctrl_pkg::*;

module ctrl_out_decode (
    input  state_t     state,
    input  logic       mem_ready,
    input  logic       rst,
    output logic       mem_req,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       alu_src_a,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic       f_sel
);

    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        alu_src_a     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        alu_op        = ALU_OP_NONE;
        f_sel         = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    // IR load and PC+4 commit only on the cycle memory delivers
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = ALU_OP_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_op    = ALU_OP_ADD;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = ALU_OP_ADD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    i_or_d  = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_REX: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_OP_FUNCT;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_OP_SUB;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'b01;
                end
                S_IEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = ALU_OP_FUNCT;
                    f_sel     = 1'b1;
                end
                S_IWB: begin
                    reg_write = 1'b1;
                end
`ifdef MIPS_JUMP_EN
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control FSM: state register + next-state logic; outputs via ctrl_out_decode.
// Ports: clk, rst (async active-high), opcode, mem_ready in; mux selects, strobes, alu_op, f_sel,
// illegal, debug state out. Stalls in FETCH/MEMRD/MEMWR until mem_ready. Macro MIPS_JUMP_EN enables j.
import mips_ctrl_pkg::*;

module main_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       alu_src_a,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic       f_sel,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    logic   op_legal;

    // Dispatch target out of DECODE; unknown opcodes fall back to FETCH
    always_comb begin
        state_d  = state_q;
        op_legal = 1'b1;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    state_d = S_REX;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (is_itype(opcode)) begin
                    state_d = S_IEX;
`ifdef MIPS_JUMP_EN
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
`endif
                end else begin
                    state_d  = S_FETCH;
                    op_legal = 1'b0;
                end
            end
            // Only lw/sw reach MEMADR, so anything not sw is treated as lw
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_REX:    state_d = S_RWB;
            S_IEX:    state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state   = state_q;
    assign illegal = !rst && (state_q == S_DECODE) && !op_legal;

    ctrl_out_decode u_out (
        .state         (state_q),
        .mem_ready     (mem_ready),
        .rst           (rst),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .alu_src_a     (alu_src_a),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .alu_src_b     (alu_src_b),
        .pc_src        (pc_src),
        .alu_op        (alu_op),
        .f_sel         (f_sel)
    );

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: every cycle's expected state and outputs
// are queued when inputs are driven and compared at the following falling edge.
module tb_main_control_fsm;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_write, i_or_d, alu_src_a, reg_dst, mem_to_reg;
    logic       pc_write, pc_write_cond, ir_write, reg_write, f_sel, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state;

    main_control_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .alu_src_a     (alu_src_a),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .alu_src_b     (alu_src_b),
        .pc_src        (pc_src),
        .alu_op        (alu_op),
        .f_sel         (f_sel),
        .illegal       (illegal),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                           MEMWB = 4'd4, MEMWR = 4'd5, REX = 4'd6, RWB = 4'd7,
                           BRANCH = 4'd8, IEX = 4'd9, IWB = 4'd10, JUMP = 4'd11;

    // {state, mem_req, mem_write, i_or_d, alu_src_a, reg_dst, mem_to_reg, pc_write,
    //  pc_write_cond, ir_write, reg_write, alu_src_b, pc_src, alu_op, f_sel, illegal}
    logic [22:0] observed;
    assign observed = {state, mem_req, mem_write, i_or_d, alu_src_a, reg_dst, mem_to_reg,
                       pc_write, pc_write_cond, ir_write, reg_write, alu_src_b, pc_src,
                       alu_op, f_sel, illegal};

    typedef struct {
        string       tag;
        logic [22:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   passes = 0;
    int   total  = 0;

    // Output table for a state, written straight from the control description
    function automatic logic [22:0] expect_for(input logic [3:0] st, input logic rdy, input logic ill);
        logic mreq, mw, iod, asa, rd, m2r, pw, pwc, irw, rw, fs;
        logic [1:0] asb, ps;
        logic [2:0] aop;
        {mreq, mw, iod, asa, rd, m2r, pw, pwc, irw, rw, fs} = '0;
        asb = 2'b00; ps = 2'b00; aop = 3'b000;
        case (st)
            FETCH:  begin mreq = 1; asb = 2'b01; aop = 3'b100; irw = rdy; pw = rdy; end
            DECODE: begin asb = 2'b11; aop = 3'b100; end
            MEMADR: begin asa = 1; asb = 2'b10; aop = 3'b100; end
            MEMRD:  begin mreq = 1; iod = 1; end
            MEMWB:  begin rw = 1; m2r = 1; end
            MEMWR:  begin mreq = 1; mw = 1; iod = 1; end
            REX:    begin asa = 1; aop = 3'b001; end
            RWB:    begin rw = 1; rd = 1; end
            BRANCH: begin asa = 1; aop = 3'b010; pwc = 1; ps = 2'b01; end
            IEX:    begin asa = 1; asb = 2'b10; aop = 3'b001; fs = 1; end
            IWB:    begin rw = 1; end
            JUMP:   begin pw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {st, mreq, mw, iod, asa, rd, m2r, pw, pwc, irw, rw, asb, ps, aop, fs, ill};
    endfunction

    task automatic check_front();
        exp_t e;
        e = exp_q.pop_front();
        total++;
        assert (observed === e.value) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h expected %h", e.tag, observed, e.value);
        end
    endtask

    // One clock of stimulus, entered just after a rising edge
    task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic ill);
        exp_t e;
        opcode    = op;
        mem_ready = rdy;
        e.tag     = tag;
        e.value   = expect_for(st, rdy, ill);
        exp_q.push_back(e);
        @(negedge clk);
        check_front();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        exp_t e;
        e.tag   = tag;
        e.value = '0;
        exp_q.push_back(e);
        check_front();
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 6'b100011;
        mem_ready = 1'b1;
        #3;
        check_reset("reset_hold");
        @(posedge clk);
        #1;
        check_reset("reset_after_edge");
        rst = 1'b0;

        // lw, memory always ready: 5 cycles
        cyc("lw_fetch",  6'b100011, 1'b1, FETCH,  1'b0);
        cyc("lw_decode", 6'b100011, 1'b0, DECODE, 1'b0);
        cyc("lw_memadr", 6'b100011, 1'b1, MEMADR, 1'b0);
        cyc("lw_memrd",  6'b100011, 1'b1, MEMRD,  1'b0);
        cyc("lw_memwb",  6'b100011, 1'b0, MEMWB,  1'b0);

        // sw with instruction fetch stalled twice and store stalled three cycles
        cyc("sw_fetch_wait0", 6'b101011, 1'b0, FETCH,  1'b0);
        cyc("sw_fetch_wait1", 6'b101011, 1'b0, FETCH,  1'b0);
        cyc("sw_fetch",       6'b101011, 1'b1, FETCH,  1'b0);
        cyc("sw_decode",      6'b101011, 1'b1, DECODE, 1'b0);
        cyc("sw_memadr",      6'b101011, 1'b0, MEMADR, 1'b0);
        cyc("sw_memwr_wait0", 6'b101011, 1'b0, MEMWR,  1'b0);
        cyc("sw_memwr_wait1", 6'b101011, 1'b0, MEMWR,  1'b0);
        cyc("sw_memwr_wait2", 6'b101011, 1'b0, MEMWR,  1'b0);
        cyc("sw_memwr_done",  6'b101011, 1'b1, MEMWR,  1'b0);

        // R-type
        cyc("r_fetch",  6'b000000, 1'b1, FETCH,  1'b0);
        cyc("r_decode", 6'b000000, 1'b1, DECODE, 1'b0);
        cyc("r_rex",    6'b000000, 1'b0, REX,    1'b0);
        cyc("r_rwb",    6'b000000, 1'b1, RWB,    1'b0);

        // addi and ori through IEX/IWB
        cyc("addi_fetch",  6'b001000, 1'b1, FETCH,  1'b0);
        cyc("addi_decode", 6'b001000, 1'b1, DECODE, 1'b0);
        cyc("addi_iex",    6'b001000, 1'b1, IEX,    1'b0);
        cyc("addi_iwb",    6'b001000, 1'b0, IWB,    1'b0);
        cyc("ori_fetch",   6'b001101, 1'b1, FETCH,  1'b0);
        cyc("ori_decode",  6'b001101, 1'b1, DECODE, 1'b0);
        cyc("ori_iex",     6'b001101, 1'b1, IEX,    1'b0);
        cyc("ori_iwb",     6'b001101, 1'b1, IWB,    1'b0);

        // beq: 3 cycles
        cyc("beq_fetch",  6'b000100, 1'b1, FETCH,  1'b0);
        cyc("beq_decode", 6'b000100, 1'b1, DECODE, 1'b0);
        cyc("beq_branch", 6'b000100, 1'b0, BRANCH, 1'b0);

        // undecodable opcode
        cyc("ill_fetch",  6'b111111, 1'b1, FETCH,  1'b0);
        cyc("ill_decode", 6'b111111, 1'b1, DECODE, 1'b1);

        // j: legal only with the jump option compiled in
        cyc("j_fetch",  6'b000010, 1'b1, FETCH,  1'b0);
`ifdef MIPS_JUMP_EN
        cyc("j_decode", 6'b000010, 1'b1, DECODE, 1'b0);
        cyc("j_jump",   6'b000010, 1'b1, JUMP,   1'b0);
`else
        cyc("j_decode_illegal", 6'b000010, 1'b1, DECODE, 1'b1);
`endif

        // lw abandoned by an asynchronous reset while stalled in MEMRD
        cyc("rst_lw_fetch",  6'b100011, 1'b1, FETCH,  1'b0);
        cyc("rst_lw_decode", 6'b100011, 1'b1, DECODE, 1'b0);
        cyc("rst_lw_memadr", 6'b100011, 1'b1, MEMADR, 1'b0);
        cyc("rst_lw_memrd",  6'b100011, 1'b0, MEMRD,  1'b0);
        #2;
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_reset("rst_async_memrd");
        @(posedge clk);
        #1;
        check_reset("rst_held_edge");
        rst = 1'b0;
        cyc("post_rst_fetch",  6'b000000, 1'b1, FETCH,  1'b0);
        cyc("post_rst_decode", 6'b000000, 1'b1, DECODE, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
